hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RSA pipeline.
- Drives the 2-bit select lines of the two Execute-stage operand forwarding muxes.
- Generates stall and flush signals for load-use hazards and taken branches.
- Sequences the fixed-latency multicycle modular-multiply unit (MMU) by holding the pipeline while it is busy.

Parameters:
- REG_ADDR_W, default 4: register address width.
- MUL_LATENCY, default 8: MMU busy cycles after start; legal range 2..2^CNT_W.
- CNT_W, default 4: busy counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ra1D, ra2D  in  REG_ADDR_W  source registers, Decode stage.
- ra1E, ra2E  in  REG_ADDR_W  source registers, Execute stage.
- wa3E, wa3M, wa3W  in  REG_ADDR_W  destination registers, E/M/W stages.
- RegWriteM, RegWriteW  in  1  destination write enable, M/W stages.
- MemtoRegE  in  1  load instruction in E.
- BranchTakenE  in  1  branch resolved taken in E.
- MulE  in  1  MMU instruction in E.
- ForwardAE, ForwardBE  out  2  forwarding mux selects.
- StallF, StallD, StallE  out  1  hold the F/D/E pipeline registers.
- FlushD, FlushE  out  1  clear the D/E pipeline registers.
- mul_start  out  1  one-cycle MMU start pulse.
- mul_done  out  1  MMU result valid, consumed this cycle.
- mul_busy  out  1  state is BUSY.

Behaviour:
- Forwarding (combinational, per operand X in {A, B}):
  - 2'b11 (ALU result, M stage) if RegWriteM and raXE == wa3M.
  - Else 2'b01 (result, W stage) if RegWriteW and raXE == wa3W.
  - Else 2'b00 (register file).
  - 2'b10 is never produced.
  - M has priority over W.
- Load-use stall (combinational): lwstall = MemtoRegE & (ra1D == wa3E | ra2D == wa3E).
- MMU FSM states: IDLE, BUSY, DONE; 2-bit registered state plus a CNT_W-bit counter.
  - IDLE: if MulE = 1, mul_start = 1 (combinational), counter <= MUL_LATENCY-1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: counter decrements each cycle; when counter == 0, go to DONE.
  - DONE: mul_done = 1, then unconditionally go to IDLE. MulE may still be high in DONE; no retrigger because the stall is released and the instruction leaves E this cycle.
- mulstall = (IDLE & MulE) | BUSY. Total MMU stall = 1 + MUL_LATENCY cycles; the instruction leaves E on the DONE cycle.
- Stall and flush outputs:
  - StallF = StallD = lwstall | mulstall.
  - StallE = mulstall.
  - FlushD = BranchTakenE & ~mulstall.
  - FlushE = (lwstall | BranchTakenE) & ~mulstall.
- Simultaneous events: mulstall dominates all flushes, since E is frozen and the branch or load cannot be in E at the same time. lwstall and BranchTakenE together give FlushE = 1 and FlushD = 1.
- Reset (async, any state, including mid-BUSY):
  - state = IDLE, counter = 0, mul_busy = 0, mul_done = 0.
  - mul_start and the stall/flush outputs then follow the IDLE-state equations.
  - An in-flight MMU operation is abandoned.
- All registered outputs update on posedge clk only.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef fwd_sel_t: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b11.
  - typedef mul_state_t: IDLE, BUSY, DONE.
- One sub-module: mul_seq. It contains the FSM and counter and exports mulstall, mul_start, mul_done and mul_busy.
- Forwarding and stall logic stay in hazard_ctrl.

Test Plan:
- Forwarding priority: ra1E = 3, wa3M = 3, wa3W = 3, RegWriteM = RegWriteW = 1 -> ForwardAE = 11. Then RegWriteM = 0 -> ForwardAE = 01. Then RegWriteW = 0 -> ForwardAE = 00. Repeat on ForwardBE.
- Load-use: MemtoRegE = 1, wa3E = 5, ra2D = 5 -> StallF = StallD = FlushE = 1, StallE = 0. With ra2D = 6 -> all 0.
- Branch: BranchTakenE = 1, MulE = 0 -> FlushD = FlushE = 1, no stalls.
- MMU sequence, MUL_LATENCY = 4: MulE = 1 held.
  - Cycle 0: mul_start = 1, stalls high.
  - Cycles 1-4: mul_busy = 1, StallE = 1.
  - Cycle 5: mul_done = 1, stalls 0.
  - Cycle 6: IDLE; a fresh MulE triggers a new mul_start.
- Reset in BUSY: assert reset asynchronously mid-cycle 2 -> mul_busy = 0 immediately, no mul_done. After release with MulE = 0 -> state stays IDLE.
- MMU plus branch: BranchTakenE = 1 during BUSY -> FlushD = FlushE = 0 until DONE.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RSA pipeline hazard controller: forwarding selects
// and the multicycle-multiply sequencer states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/hazard_ctrl_mul_seq.sv
// Fixed-latency modular-multiply sequencer: holds the pipeline from the
// start cycle through MUL_LATENCY busy cycles, then signals completion.
module mul_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mul_e,
    output logic mulstall,
    output logic mul_start,
    output logic mul_done,
    output logic mul_busy
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MUL_LATENCY - 1);

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mul_busy <= 1'b0;
            mul_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mul_done <= 1'b0;
                    if (mul_e) begin
                        state    <= BUSY;
                        cnt      <= LOAD;
                        mul_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        mul_busy <= 1'b0;
                        mul_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // MulE may still be high here; the instruction leaves E
                    // this cycle, so no retrigger.
                    state    <= IDLE;
                    mul_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    mul_busy <= 1'b0;
                    mul_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mul_start = (state == IDLE) && mul_e;
        mulstall  = mul_start || (state == BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: Execute-stage forwarding selects, load-use stall,
// branch flush, and pipeline hold while the multiply unit is busy.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MUL_LATENCY = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ra1D,
    input  logic [REG_ADDR_W-1:0] ra2D,
    input  logic [REG_ADDR_W-1:0] ra1E,
    input  logic [REG_ADDR_W-1:0] ra2E,
    input  logic [REG_ADDR_W-1:0] wa3E,
    input  logic [REG_ADDR_W-1:0] wa3M,
    input  logic [REG_ADDR_W-1:0] wa3W,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  BranchTakenE,
    input  logic                  MulE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  mul_start,
    output logic                  mul_done,
    output logic                  mul_busy
);

    logic lwstall;
    logic mulstall;

    // The M-stage result is younger than W, so it wins when both match.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_ADDR_W-1:0] ra,
        input logic [REG_ADDR_W-1:0] wa_m,
        input logic [REG_ADDR_W-1:0] wa_w,
        input logic                  we_m,
        input logic                  we_w
    );
        if (we_m && (ra == wa_m))
            return FWD_MEM;
        else if (we_w && (ra == wa_w))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    mul_seq #(
        .MUL_LATENCY(MUL_LATENCY),
        .CNT_W      (CNT_W)
    ) u_mul_seq (
        .clk      (clk),
        .reset    (reset),
        .mul_e    (MulE),
        .mulstall (mulstall),
        .mul_start(mul_start),
        .mul_done (mul_done),
        .mul_busy (mul_busy)
    );

    always_comb begin
        ForwardAE = fwd_select(ra1E, wa3M, wa3W, RegWriteM, RegWriteW);
        ForwardBE = fwd_select(ra2E, wa3M, wa3W, RegWriteM, RegWriteW);
    end

    always_comb begin
        lwstall = MemtoRegE && ((ra1D == wa3E) || (ra2D == wa3E));
        StallF  = lwstall || mulstall;
        StallD  = lwstall || mulstall;
        StallE  = mulstall;
        // A frozen E stage cannot also hold the branch or load, so the
        // multiply hold suppresses every flush.
        FlushD  = BranchTakenE && !mulstall;
        FlushE  = (lwstall || BranchTakenE) && !mulstall;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks for hazard_ctrl with a 4-cycle multiply latency.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic       mul_start, mul_done, mul_busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W (4),
        .MUL_LATENCY(4),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ra1D        (ra1D),
        .ra2D        (ra2D),
        .ra1E        (ra1E),
        .ra2E        (ra2E),
        .wa3E        (wa3E),
        .wa3M        (wa3M),
        .wa3W        (wa3W),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .BranchTakenE(BranchTakenE),
        .MulE        (MulE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .mul_busy    (mul_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Packs {StallF,StallD,StallE,FlushD,FlushE} for compact comparisons.
    function automatic logic [4:0] ctl();
        return {StallF, StallD, StallE, FlushD, FlushE};
    endfunction

    // Packs {mul_start,mul_busy,mul_done}.
    function automatic logic [2:0] mst();
        return {mul_start, mul_busy, mul_done};
    endfunction

    task automatic quiet();
        ra1D = 4'd1; ra2D = 4'd2; ra1E = 4'd7; ra2E = 4'd8;
        wa3E = 4'd9; wa3M = 4'd10; wa3W = 4'd11;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        BranchTakenE = 1'b0; MulE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        #1;
        check("rst_mul", 32'(mst()), 32'b000);
        check("rst_ctl", 32'(ctl()), 32'b00000);
        #12 reset = 1'b0;
        step();
        check("idle_mul", 32'(mst()), 32'b000);

        // Forwarding priority on A then B
        ra1E = 4'd3; wa3M = 4'd3; wa3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1 check("fwdA_mem", 32'(ForwardAE), 32'b11);
        RegWriteM = 1'b0;
        #1 check("fwdA_wb", 32'(ForwardAE), 32'b01);
        RegWriteW = 1'b0;
        #1 check("fwdA_rf", 32'(ForwardAE), 32'b00);
        ra1E = 4'd7; ra2E = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1 check("fwdB_mem", 32'(ForwardBE), 32'b11);
        check("fwdA_nomatch", 32'(ForwardAE), 32'b00);
        RegWriteM = 1'b0;
        #1 check("fwdB_wb", 32'(ForwardBE), 32'b01);
        RegWriteW = 1'b0;
        #1 check("fwdB_rf", 32'(ForwardBE), 32'b00);
        wa3M = 4'd4; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1 check("fwdB_wb_only", 32'(ForwardBE), 32'b01);
        quiet();

        // Load-use
        MemtoRegE = 1'b1; wa3E = 4'd5; ra2D = 4'd5;
        #1 check("lw_ra2", 32'(ctl()), 32'b11001);
        ra2D = 4'd6;
        #1 check("lw_nomatch", 32'(ctl()), 32'b00000);
        ra1D = 4'd5;
        #1 check("lw_ra1", 32'(ctl()), 32'b11001);
        MemtoRegE = 1'b0;
        #1 check("lw_noload", 32'(ctl()), 32'b00000);
        quiet();

        // Branch, alone and with a load-use
        BranchTakenE = 1'b1;
        #1 check("br", 32'(ctl()), 32'b00011);
        MemtoRegE = 1'b1; wa3E = 4'd1;
        #1 check("br_lw", 32'(ctl()), 32'b11011);
        quiet();

        // Multiply sequence, MulE held: start, 4 busy, done, restart
        step();
        MulE = 1'b1;
        #1 check("mul_c0_st", 32'(mst()), 32'b100);
        check("mul_c0_ctl", 32'(ctl()), 32'b11100);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("mul_c%0d_st", i), 32'(mst()), 32'b010);
            check($sformatf("mul_c%0d_ctl", i), 32'(ctl()), 32'b11100);
        end
        step();
        check("mul_c5_st", 32'(mst()), 32'b001);
        check("mul_c5_ctl", 32'(ctl()), 32'b00000);
        step();
        check("mul_c6_st", 32'(mst()), 32'b100);
        check("mul_c6_ctl", 32'(ctl()), 32'b11100);
        step();
        check("mul_c7_busy", 32'(mst()), 32'b010);

        // Async reset mid-BUSY
        step();
        MulE = 1'b0;
        #3 reset = 1'b1;
        #1 check("rstbusy_st", 32'(mst()), 32'b000);
        check("rstbusy_ctl", 32'(ctl()), 32'b00000);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_rst%0d", i), 32'(mst()), 32'b000);
        end

        // Branch during BUSY is held off until DONE
        MulE = 1'b1;
        #1 check("mb_start", 32'(mst()), 32'b100);
        step();
        BranchTakenE = 1'b1;
        #1 check("mb_b1", 32'(ctl()), 32'b11100);
        for (int i = 2; i <= 4; i++) begin
            step();
            check($sformatf("mb_b%0d", i), 32'(ctl()), 32'b11100);
        end
        step();
        check("mb_done_st", 32'(mst()), 32'b001);
        check("mb_done_ctl", 32'(ctl()), 32'b00011);
        quiet();
        step();
        check("mb_idle", 32'(mst()), 32'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
